// File: rtl/mure_pkg.sv
// Shared types for the trace-encoder connector: commit entry format, scheduler
// state encoding and sizing constants.
package mure_pkg;

    localparam int unsigned SCHED_DEPTH  = 8;
    localparam int unsigned DROP_CNT_LEN = 16;

    // One committed instruction as delivered by a CVA6 commit port.
    typedef struct packed {
        logic        valid;
        logic [3:0]  itype;
        logic [31:0] pc;
    } fifo_entry_s;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sched_state_e;

endpackage

// File: rtl/te_entry_scheduler_if.sv
// Bundle between the commit ports / block-building FSM and te_entry_scheduler.
// drop_cnt_o only exists when TE_SCHED_DROP_CNT_EN is defined.
interface te_entry_scheduler_if
    import mure_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = SCHED_DEPTH
) ();

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    // Handshake: the commit side cannot stall, so entry_i[p].valid is accepted
    // unconditionally (ready_o is advisory). Downstream, entry_o.valid is only
    // raised while dst_ready_i is high, and every cycle with entry_o.valid=1 is
    // a completed transfer that pops the head entry.
    fifo_entry_s [NRET-1:0] entry_i;
    logic                   flush_i;
    logic                   dst_ready_i;
    fifo_entry_s            entry_o;
    logic                   ready_o;
    logic                   overflow_o;
    logic                   resync_o;
    logic [LW-1:0]          level_o;
    sched_state_e           state_o;
`ifdef TE_SCHED_DROP_CNT_EN
    logic [DROP_CNT_LEN-1:0] drop_cnt_o;
`endif

    modport slave (
        input  entry_i,
        input  flush_i,
        input  dst_ready_i,
        output entry_o,
        output ready_o,
        output overflow_o,
        output resync_o,
        output level_o,
`ifdef TE_SCHED_DROP_CNT_EN
        output drop_cnt_o,
`endif
        output state_o
    );

    modport master (
        output entry_i,
        output flush_i,
        output dst_ready_i,
        input  entry_o,
        input  ready_o,
        input  overflow_o,
        input  resync_o,
        input  level_o,
`ifdef TE_SCHED_DROP_CNT_EN
        input  drop_cnt_o,
`endif
        input  state_o
    );

endinterface

// File: rtl/te_entry_scheduler_buf.sv
// Circular entry buffer: compacting NRET-wide write, single read at rd_ptr,
// occupancy exposed as level_o.
module te_entry_buf
    import mure_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = SCHED_DEPTH,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned LW   = PW + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clr_i,
    input  fifo_entry_s [NRET-1:0] wr_data_i,
    input  logic [NRET-1:0]        wr_en_i,
    input  logic                   pop_i,
    output fifo_entry_s            rd_data_o,
    output logic [LW-1:0]          level_o
);

    fifo_entry_s   mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [PW-1:0] wr_idx [NRET];
    logic [LW-1:0] push_cnt;

    // Each enabled port lands after the enabled ports older than it.
    always_comb begin
        push_cnt = '0;
        for (int p = 0; p < NRET; p++) begin
            wr_idx[p] = wr_ptr_q + push_cnt[PW-1:0];
            if (wr_en_i[p]) begin
                push_cnt = push_cnt + LW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + push_cnt[PW-1:0];
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            level_q <= level_q + push_cnt - LW'(pop_i);
        end
    end

    // Storage is not reset; stale slots are never read while level is 0.
    always_ff @(posedge clk_i) begin
        for (int p = 0; p < NRET; p++) begin
            if (wr_en_i[p]) begin
                mem_q[wr_idx[p]] <= wr_data_i[p];
            end
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

endmodule

// File: rtl/te_entry_scheduler.sv
// Commit-entry scheduler: buffers up to NRET entries per cycle, issues one per
// cycle in program order, drains and resyncs after overflow. TE_SCHED_DROP_CNT_EN adds drop_cnt_o.
module te_entry_scheduler
    import mure_pkg::*;
#(
    parameter int unsigned NRET  = 2,
    parameter int unsigned DEPTH = SCHED_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    te_entry_scheduler_if.slave   bus
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    sched_state_e    state_q, state_d;
    logic            overflow_q, overflow_d;
    logic            resync_q, resync_d;
    logic [LW-1:0]   level;
    logic [LW-1:0]   free_slots;
    logic [LW-1:0]   in_cnt;
    logic [LW-1:0]   acc_cnt;
    logic [LW-1:0]   drop_cnt;
    logic [NRET-1:0] wr_en;
    logic            issue;
    fifo_entry_s     head;
    fifo_entry_s     issued;

    te_entry_buf #(
        .NRET  (NRET),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (bus.flush_i),
        .wr_data_i (bus.entry_i),
        .wr_en_i   (wr_en),
        .pop_i     (issue),
        .rd_data_o (head),
        .level_o   (level)
    );

    // Free space uses pre-pop occupancy: a same-cycle pop never makes room.
    assign free_slots = LW'(DEPTH) - level;

    // Accept the oldest live entries that fit; everything else is dropped.
    always_comb begin
        in_cnt  = '0;
        acc_cnt = '0;
        wr_en   = '0;
        for (int p = 0; p < NRET; p++) begin
            if (bus.entry_i[p].valid) begin
                if (state_q == RUN && !bus.flush_i && in_cnt < free_slots) begin
                    wr_en[p] = 1'b1;
                    acc_cnt  = acc_cnt + LW'(1);
                end
                in_cnt = in_cnt + LW'(1);
            end
        end
        drop_cnt = in_cnt - acc_cnt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            overflow_q <= 1'b0;
            resync_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            overflow_q <= overflow_d;
            resync_q   <= resync_d;
        end
    end

    // Flush beats everything, including the DRAIN exit and its resync pulse.
    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        resync_d   = 1'b0;
        if (bus.flush_i) begin
            state_d    = RUN;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (drop_cnt != '0) begin
                        state_d    = DRAIN;
                        overflow_d = 1'b1;
                    end
                end
                DRAIN: begin
                    if (level == '0) begin
                        state_d  = RUN;
                        resync_d = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    assign issue = (level != '0) && bus.dst_ready_i && !bus.flush_i;

    always_comb begin
        issued = '0;
        if (issue) begin
            issued       = head;
            issued.valid = 1'b1;
        end
    end

    assign bus.entry_o    = issued;
    assign bus.ready_o    = free_slots >= LW'(NRET);
    assign bus.overflow_o = overflow_q;
    assign bus.resync_o   = resync_q;
    assign bus.level_o    = level;
    assign bus.state_o    = state_q;

`ifdef TE_SCHED_DROP_CNT_EN
    logic [DROP_CNT_LEN-1:0] drop_cnt_q;
    logic [DROP_CNT_LEN:0]   drop_sum;

    assign drop_sum = {1'b0, drop_cnt_q} + (DROP_CNT_LEN + 1)'(drop_cnt);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || bus.flush_i) begin
            drop_cnt_q <= '0;
        end else if (drop_sum[DROP_CNT_LEN]) begin
            drop_cnt_q <= '1;
        end else begin
            drop_cnt_q <= drop_sum[DROP_CNT_LEN-1:0];
        end
    end

    assign bus.drop_cnt_o = drop_cnt_q;
`endif

endmodule
